// File: rtl/switch_pkg.sv
// Types and default widths shared by the address switch and its ingress queue.
package switch_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sw_word_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, asynchronous head read.
module sync_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is not reset: contents are only observed after being written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/switch_ingress_queue.sv
// Ingress FIFO in front of the address switch: absorbs producer bursts and
// drains one entry per enabled cycle as a single-cycle strobe.
module switch_ingress_queue
  import switch_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic [ADDR_WIDTH-1:0]      in_addr,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       drain_en,
  output logic                       out_vld,
  output logic [ADDR_WIDTH-1:0]      out_addr,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_WIDTH-1:0]       refused
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] REF_MAX  = {CNT_WIDTH{1'b1}};

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_WIDTH-1:0]  refused_q, refused_d;
  logic                  out_vld_q, out_vld_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                  full_s;
  logic                  push_s;
  logic                  pop_s;
  logic [WORD_W-1:0]     head_s;

  // Ready depends only on registered occupancy, so no path from in_vld.
  assign full_s = (count_q == FULL_CNT);
  assign in_rdy = !full_s;
  assign push_s = in_vld && !full_s;
  assign pop_s  = drain_en && (count_q != {CNT_W{1'b0}});

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_q),
    .wdata ({in_addr, in_data}),
    .raddr (rd_ptr_q),
    .rdata (head_s)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    refused_d  = refused_q;
    out_vld_d  = 1'b0;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      out_vld_d  = 1'b1;
      out_addr_d = head_s[WORD_W-1:DATA_WIDTH];
      out_data_d = head_s[DATA_WIDTH-1:0];
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Refused attempts saturate rather than wrap.
    if (in_vld && full_s && (refused_q != REF_MAX)) begin
      refused_d = refused_q + CNT_WIDTH'(1);
    end else begin
      refused_d = refused_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      refused_q  <= {CNT_WIDTH{1'b0}};
      out_vld_q  <= 1'b0;
      out_addr_q <= {ADDR_WIDTH{1'b0}};
      out_data_q <= {DATA_WIDTH{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      refused_q  <= refused_d;
      out_vld_q  <= out_vld_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;
  assign count    = count_q;
  assign refused  = refused_q;

endmodule

// File: tb/tb_switch_ingress_queue.sv
// Scoreboard bench: driver feeds a queue-based reference model, a negedge
// monitor compares every output strobe and status signal against it.
module tb_switch_ingress_queue;
  import switch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_vld = 1'b0;
  logic [7:0]  in_addr = 8'h00;
  logic [15:0] in_data = 16'h0000;
  logic        drain_en = 1'b0;

  logic        in_rdy, out_vld;
  logic [7:0]  out_addr;
  logic [15:0] out_data;
  logic [2:0]  count;
  logic [7:0]  refused;

  logic        in_rdy2, out_vld2;
  logic [7:0]  out_addr2;
  logic [15:0] out_data2;
  logic [2:0]  count2;
  logic [1:0]  refused2;

  int checks = 0;
  int errors = 0;

  sw_word_t m_q[$];
  sw_word_t exp_q[$];
  int       m_ref  = 0;
  int       m_ref2 = 0;

  always #5 clk = ~clk;

  switch_ingress_queue #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_addr(in_addr),
    .in_data(in_data), .drain_en(drain_en), .out_vld(out_vld), .out_addr(out_addr),
    .out_data(out_data), .count(count), .refused(refused));

  switch_ingress_queue #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(DEPTH), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy2), .in_addr(in_addr),
    .in_data(in_data), .drain_en(drain_en), .out_vld(out_vld2), .out_addr(out_addr2),
    .out_data(out_data2), .count(count2), .refused(refused2));

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the model advances by the queue rules at the edge.
  task automatic cyc(input logic v, input logic [7:0] a, input logic [15:0] d, input logic dr);
    bit rdy, push, pop;
    sw_word_t w;
    in_vld = v; in_addr = a; in_data = d; drain_en = dr;
    rdy  = (m_q.size() < DEPTH);
    push = v && rdy;
    pop  = dr && (m_q.size() > 0);
    @(posedge clk);
    if (pop) begin
      w = m_q.pop_front();
      exp_q.push_back(w);
    end
    if (push) begin
      w.addr = a; w.data = d;
      m_q.push_back(w);
    end
    if (v && !rdy) begin
      if (m_ref < 255) m_ref++;
      if (m_ref2 < 3) m_ref2++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 16'h0000, 1'b1);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    in_vld = 1'b0; drain_en = 1'b0;
    m_q.delete(); exp_q.delete();
    m_ref = 0; m_ref2 = 0;
    #1;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_count", count, 0);
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_refused", refused, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: compares strobes against the scoreboard and status against the model.
  always @(negedge clk) begin
    sw_word_t e;
    chk("out_vld", out_vld, (exp_q.size() != 0));
    chk("out_vld2", out_vld2, (exp_q.size() != 0));
    if (out_vld && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("out_addr", out_addr, e.addr);
      chk("out_data", out_data, e.data);
      chk("out_data2", {out_addr2, out_data2}, e);
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    chk("count", count, m_q.size());
    chk("count2", count2, m_q.size());
    chk("in_rdy", in_rdy, (m_q.size() < DEPTH));
    chk("refused", refused, m_ref);
    chk("refused_sat", refused2, m_ref2);
  end

  initial begin
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Single word, minimum latency.
    cyc(1'b1, 8'h12, 16'hBEEF, 1'b1);
    idle(3);

    // Fill with drain disabled, three refused, then drain in order.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 16'(i * 16'h0101), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hEE, 16'hEEEE, 1'b0);
    idle(5);

    // Simultaneous push and pop at occupancy 2, wrapping pointers.
    cyc(1'b1, 8'h20, 16'h2000, 1'b0);
    cyc(1'b1, 8'h21, 16'h2001, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h22 + i), 16'(16'h2002 + i), 1'b1);
    idle(3);

    // Full with push and pop in the same cycle: push refused.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h30 + i), 16'(16'h3000 + i), 1'b0);
    cyc(1'b1, 8'h3F, 16'h3FFF, 1'b1);
    cyc(1'b0, 8'h00, 16'h0000, 1'b0);
    idle(4);

    // Reset mid-stream with three entries queued.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h50 + i), 16'(16'h5000 + i), 1'b0);
    do_reset();
    cyc(1'b1, 8'h40, 16'h0001, 1'b0);
    idle(3);

    // Saturation of the narrow counter and random traffic.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h60 + i), 16'(16'h6000 + i), 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'h6F, 16'h6FFF, 1'b0);
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 3) != 0), 8'($urandom), 16'($urandom), ($urandom_range(0, 2) != 0));
    idle(DEPTH + 3);

    chk("model_drained", m_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
